rom_adder_arbiter: RTL

Shares one ROM-based truth-table adder (the rom_sixteen_sma_truth_table datapath: registered, sum = a + b, DATA_WIDTH+1 bits) between NUM_REQ requesters. Round-robin arbitration accepts at most one operand pair per cycle. It drives the adder inputs, tracks each in-flight operation's requester ID through a tag pipeline matched to the ROM latency, and returns each registered sum tagged with that ID. It sits between the processing clients and the single adder instance.

---
 rtl/rom_adder_arbiter_if.sv | 28 ++
 rtl/rom_adder_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/rom_adder_arbiter_if.sv
// Bus bundle between the requesters, the shared ROM adder and the response sink.
// The slave modport is the arbiter's view; master is the environment's view.
interface rom_adder_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [DATA_WIDTH-1:0]         rom_a;
    logic [DATA_WIDTH-1:0]         rom_b;
    logic [DATA_WIDTH:0]           rom_sum;
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH:0]           rsp_sum;

    modport slave (
        input  req_valid, req_a, req_b, rom_sum,
        output req_ready, rom_a, rom_b, rsp_valid, rsp_id, rsp_sum
    );

    modport master (
        output req_valid, req_a, req_b, rom_sum,
        input  req_ready, rom_a, rom_b, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/rom_adder_arbiter.sv
// Round-robin front end sharing one registered ROM adder among NUM_REQ requesters;
// a tag pipeline matched to the adder latency returns each sum with its requester ID.
module rom_adder_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 4,
    parameter int ROM_LATENCY = 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    rom_adder_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [15:0]          op_count
);

    logic [ID_W-1:0]                  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]            rom_a_q, rom_a_d;
    logic [DATA_WIDTH-1:0]            rom_b_q, rom_b_d;
    logic [ROM_LATENCY:0]             tag_vld_q, tag_vld_d;
    logic [ROM_LATENCY:0][ID_W-1:0]   tag_id_q, tag_id_d;
    logic                             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH:0]              rsp_sum_q, rsp_sum_d;
    logic [15:0]                      op_count_q, op_count_d;

    logic                             gnt_found;
    logic [ID_W-1:0]                  gnt_id;
    logic [ID_W:0]                    cand_wide;
    logic [ID_W-1:0]                  cand;
    logic                             accept;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand_wide = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_wide = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand_wide >= (ID_W+1)'(NUM_REQ)) begin
                cand_wide = cand_wide - (ID_W+1)'(NUM_REQ);
            end
            cand = cand_wide[ID_W-1:0];
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        accept        = gnt_found && en && rst_n;
        bus.req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
    end

    always_comb begin
        ptr_d   = ptr_q;
        rom_a_d = rom_a_q;
        rom_b_d = rom_b_q;
        if (accept) begin
            rom_a_d = bus.req_a[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            rom_b_d = bus.req_b[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            ptr_d   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end

        // Tags shift unconditionally: the adder has no stall.
        tag_vld_d = {tag_vld_q[ROM_LATENCY-1:0], accept};
        tag_id_d  = {tag_id_q[ROM_LATENCY-1:0], gnt_id};

        rsp_valid_d = tag_vld_q[ROM_LATENCY];
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        op_count_d  = op_count_q;
        if (tag_vld_q[ROM_LATENCY]) begin
            rsp_id_d   = tag_id_q[ROM_LATENCY];
            rsp_sum_d  = bus.rom_sum;
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rom_a_q     <= '0;
            rom_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            op_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rom_a_q     <= rom_a_d;
            rom_b_q     <= rom_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.rom_a     = rom_a_q;
    assign bus.rom_b     = rom_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign busy          = (|tag_vld_q) | rsp_valid_q;
    assign op_count      = op_count_q;

endmodule
